// File: rtl/wptr_full_if.sv
// Write-side pointer interface for the dual-clock FIFO.
// Carries the producer request and synchronized read pointer in, and the
// Gray write pointer, RAM address/enable and status flags out.
//   master : producer/FIFO-top side (drives wr_inc, r2w_ptr, ovf_clr)
//   slave  : wptr_full block (drives pointer, address, enable and flags)
interface wptr_full_if #(
  parameter int unsigned ASIZE = 4
);
  logic             wr_inc;
  logic [ASIZE:0]   r2w_ptr;
  logic             ovf_clr;
  logic [ASIZE:0]   wr_ptr;
  logic [ASIZE-1:0] wr_addr;
  logic             wr_en;
  logic             wr_full;
  logic             wr_almost_full;
  logic [ASIZE:0]   wr_level;
  logic             wr_overflow;

  modport master (
    output wr_inc, r2w_ptr, ovf_clr,
    input  wr_ptr, wr_addr, wr_en, wr_full, wr_almost_full, wr_level, wr_overflow
  );

  modport slave (
    input  wr_inc, r2w_ptr, ovf_clr,
    output wr_ptr, wr_addr, wr_en, wr_full, wr_almost_full, wr_level, wr_overflow
  );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer and status generator for the dual-clock FIFO.
// Ports:
//   wr_clk    : write-domain clock
//   wr_rst_n  : asynchronous active-low reset
//   bus       : wptr_full_if.slave
//     in  : wr_inc (write request), r2w_ptr (synchronized Gray read ptr),
//           ovf_clr (synchronous clear of wr_overflow)
//     out : wr_ptr (registered Gray write ptr), wr_addr (binary RAM address),
//           wr_en (combinational RAM write enable), wr_full, wr_almost_full,
//           wr_level (fill count 0..2**ASIZE), wr_overflow (sticky)
module wptr_full #(
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic         wr_clk,
  input  logic         wr_rst_n,
  wptr_full_if.slave   bus
);

  localparam int unsigned PW       = ASIZE + 1;
  localparam int unsigned DEPTH    = 1 << ASIZE;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wgray_q;
  logic [PW-1:0] level_q;
  logic          full_q;
  logic          afull_q;
  logic          ovf_q;

  logic          accept;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_gray;
  logic          full_next;
  logic          afull_next;
  logic          ovf_next;

  // Write accepted only when not full and not held in reset.
  assign accept = bus.wr_inc & ~full_q & wr_rst_n;

  // Next binary/Gray write pointer.
  always_comb begin
    wbin_next  = wbin_q + PW'(accept);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
  end

  // Gray-to-binary of the synchronized read pointer: each bit is the XOR of
  // all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin[i] = ^(bus.r2w_ptr >> i);
    end
  end

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray form that is the read pointer with its top two bits inverted.
  always_comb begin
    full_gray  = {~bus.r2w_ptr[PW-1:PW-2], bus.r2w_ptr[PW-3:0]};
    full_next  = (wgray_next == full_gray);
    level_next = wbin_next - rbin;
    afull_next = (level_next >= PW'(AF_LEVEL));
  end

  // Sticky overflow; a set in the same cycle as a clear wins.
  always_comb begin
    ovf_next = ovf_q;
    if (bus.wr_inc && full_q) begin
      ovf_next = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_next = 1'b0;
    end
  end

  // State and status registers.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_next;
      wgray_q <= wgray_next;
      level_q <= level_next;
      full_q  <= full_next;
      afull_q <= afull_next;
      ovf_q   <= ovf_next;
    end
  end

  assign bus.wr_ptr         = wgray_q;
  assign bus.wr_addr        = wbin_q[ASIZE-1:0];
  assign bus.wr_en          = accept;
  assign bus.wr_full        = full_q;
  assign bus.wr_almost_full = afull_q;
  assign bus.wr_level       = level_q;
  assign bus.wr_overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed scenarios plus randomized
// traffic compared against a counting model of the FIFO write side.
module tb_wptr_full;

  localparam int ASIZE = 4;
  localparam int AF    = 2;
  localparam int DEPTH = 1 << ASIZE;
  localparam int MODW  = 2 * DEPTH;

  logic wr_clk;
  logic wr_rst_n;

  wptr_full_if #(.ASIZE(ASIZE)) bus ();

  wptr_full #(.ASIZE(ASIZE), .AF_MARGIN(AF)) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .bus      (bus)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  int errors = 0;
  int checks = 0;

  // Model state: total writes accepted and reads seen, both mod 2*DEPTH.
  int m_w;
  int m_r;
  int m_lvl;
  bit m_full;
  bit m_af;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ASIZE:0] gray(input int b);
    logic [ASIZE:0] v;
    v = (ASIZE+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_lvl = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ptr"},   32'(bus.wr_ptr),         32'(gray(m_w)));
    check({tag, ".addr"},  32'(bus.wr_addr),        32'(m_w % DEPTH));
    check({tag, ".full"},  32'(bus.wr_full),        32'(m_full));
    check({tag, ".af"},    32'(bus.wr_almost_full), 32'(m_af));
    check({tag, ".level"}, 32'(bus.wr_level),       32'(m_lvl));
    check({tag, ".ovf"},   32'(bus.wr_overflow),    32'(m_ovf));
  endtask

  // One clock cycle, entered and left just after a falling edge.
  // rd asks the read side to advance by one if anything is outstanding.
  task automatic cycle(input bit inc, input bit rd, input bit clr);
    logic [ASIZE:0] prev_ptr;
    bit acc;
    if (rd && m_r != m_w) m_r = (m_r + 1) % MODW;
    bus.wr_inc  = inc;
    bus.r2w_ptr = gray(m_r);
    bus.ovf_clr = clr;
    #1;
    check("wr_en", 32'(bus.wr_en), 32'(inc && !m_full));
    prev_ptr = bus.wr_ptr;
    acc   = inc && !m_full;
    m_ovf = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_w   = (m_w + int'(acc)) % MODW;
    m_lvl = (m_w - m_r + MODW) % MODW;
    m_full = (m_lvl == DEPTH);
    m_af   = (m_lvl >= DEPTH - AF);
    @(posedge wr_clk);
    #1;
    check_outputs("cyc");
    check("gray_step", 32'($countones(prev_ptr ^ bus.wr_ptr) <= 1), 32'd1);
    @(negedge wr_clk);
  endtask

  // Synchronous-style entry into reset from the cycle phase, released later.
  task automatic do_reset();
    @(negedge wr_clk);
    wr_rst_n = 1'b0;
    bus.wr_inc = 1'b0; bus.ovf_clr = 1'b0; bus.r2w_ptr = '0;
    model_reset();
    repeat (2) @(negedge wr_clk);
    wr_rst_n = 1'b1;
  endtask

  initial begin
    wr_rst_n    = 1'b0;
    bus.wr_inc  = 1'b0;
    bus.r2w_ptr = '0;
    bus.ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge wr_clk);
    check_outputs("reset");
    bus.wr_inc = 1'b1;
    #1;
    check("reset.wr_en", 32'(bus.wr_en), 32'd0);
    bus.wr_inc = 1'b0;
    wr_rst_n = 1'b1;

    // Fill 16 writes with read pointer parked at 0.
    for (int i = 0; i < DEPTH; i++) begin
      check("fill.addr", 32'(bus.wr_addr), 32'(i));
      cycle(1, 0, 0);
    end
    check("fill.ptr16", 32'(bus.wr_ptr), 32'h18);
    check("fill.full16", 32'(bus.wr_full), 32'd1);
    check("fill.level16", 32'(bus.wr_level), 32'd16);

    // Writes while full overflow and are refused; then clear.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check("ovf.set", 32'(bus.wr_overflow), 32'd1);
    check("ovf.held_ptr", 32'(bus.wr_ptr), 32'h18);
    cycle(0, 0, 1);
    check("ovf.clr", 32'(bus.wr_overflow), 32'd0);

    // One read frees a slot.
    cycle(0, 1, 0);
    check("free.full", 32'(bus.wr_full), 32'd0);
    check("free.level", 32'(bus.wr_level), 32'd15);
    check("free.af", 32'(bus.wr_almost_full), 32'd1);
    check("free.addr", 32'(bus.wr_addr), 32'd0);
    cycle(1, 0, 0);

    // Set and clear in the same cycle: set wins.
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    check("ovf.set_wins", 32'(bus.wr_overflow), 32'd1);

    // Steady 1-in/1-out at level 3 across the pointer wrap.
    do_reset();
    repeat (3) cycle(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0);
      check("steady.level", 32'(bus.wr_level), 32'd3);
    end

    // Almost-full threshold at 13/14.
    do_reset();
    repeat (13) cycle(1, 0, 0);
    check("af.at13", 32'(bus.wr_almost_full), 32'd0);
    cycle(1, 0, 0);
    check("af.at14", 32'(bus.wr_almost_full), 32'd1);

    // Asynchronous reset mid-burst at level 9.
    do_reset();
    repeat (9) cycle(1, 0, 0);
    check("burst.level9", 32'(bus.wr_level), 32'd9);
    bus.wr_inc = 1'b1;
    #2;
    wr_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.wr_en", 32'(bus.wr_en), 32'd0);
    bus.r2w_ptr = '0;
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    check("resume.addr", 32'(bus.wr_addr), 32'd0);
    cycle(1, 0, 0);
    check("resume.addr1", 32'(bus.wr_addr), 32'd1);

    // Randomized traffic in epochs with varying write/read pressure.
    for (int e = 0; e < 12; e++) begin
      int pinc;
      int prd;
      pinc = $urandom_range(1, 4);
      prd  = $urandom_range(0, 4);
      for (int i = 0; i < 60; i++) begin
        cycle($urandom_range(0, 3) < pinc,
              $urandom_range(0, 3) < prd,
              $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-side pointer and status generator for the dual-clock FIFO. Runs entirely in the write clock domain.
- Advances the binary write address on accepted writes and produces the Gray-coded write pointer that is sent to the read-side synchronizer.
- Consumes the read pointer after it has been synchronized into the write domain by the two-flop stage. From it, derives full, almost-full, fill level and a sticky overflow flag.

Parameters:
- ASIZE, 4: address width; FIFO depth = 2**ASIZE.
- AF_MARGIN, 2: almost-full asserts when free entries <= AF_MARGIN. Legal range 1..2**ASIZE-1.

Ports:
- wr_clk, input, 1: write-domain clock; all state updates on its rising edge.
- wr_rst_n, input, 1: asynchronous, active-low reset.
- wr_inc, input, 1: write request from the producer.
- r2w_ptr, input, ASIZE+1: Gray read pointer, already synchronized into wr_clk.
- ovf_clr, input, 1: synchronous clear of wr_overflow.
- wr_ptr, output, ASIZE+1: registered Gray write pointer, sent to the read-side synchronizer.
- wr_addr, output, ASIZE: binary RAM write address (low ASIZE bits of the binary pointer).
- wr_en, output, 1: RAM write enable; combinational, equal to wr_inc & ~wr_full.
- wr_full, output, 1: registered full flag.
- wr_almost_full, output, 1: registered almost-full flag.
- wr_level, output, ASIZE+1: registered fill count, 0..2**ASIZE.
- wr_overflow, output, 1: sticky flag; set by a write attempted while full.

Behaviour:
- Reset (wr_rst_n low, asynchronous):
  - binary pointer wbin = 0, wr_ptr = 0, wr_addr = 0.
  - wr_full = 0, wr_almost_full = 0, wr_level = 0, wr_overflow = 0.
  - wr_en = 0 while in reset regardless of wr_inc.
  - Reset deassertion mid-stream returns to the empty state; no pending write is retained.
- Pointer update:
  - wbin_next = wbin + (wr_inc & ~wr_full), mod 2**(ASIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Both are registered each cycle. wr_ptr changes at most one bit per cycle.
  - wr_addr = wbin[ASIZE-1:0]. The RAM writes at the current wr_addr in the same cycle that wr_en is high.
- Full detection:
  - full_next = (wgray_next == {~r2w_ptr[ASIZE:ASIZE-1], r2w_ptr[ASIZE-2:0]}); registered into wr_full.
  - wr_full rises on the edge that accepts the 2**ASIZE-th outstanding write, so no extra write can slip in.
  - wr_full deasserts only after the read pointer has propagated through the synchronizer (pessimistic; never optimistic).
- Level:
  - rbin = Gray-to-binary of r2w_ptr, using an XOR prefix from the MSB.
  - level_next = (wbin_next - rbin) mod 2**(ASIZE+1); registered into wr_level. Range 0..2**ASIZE.
  - wr_almost_full is registered as (level_next >= 2**ASIZE - AF_MARGIN). It is high whenever wr_full is high.
- Overflow:
  - wr_overflow is set on any cycle with wr_inc & wr_full. The pointer does not advance on that cycle.
  - Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Wrap-around:
  - wbin rolls from 2**(ASIZE+1)-1 to 0 with no special handling. The extra MSB distinguishes full from empty.
- Simultaneous events:
  - A write and a read-pointer change in the same cycle are both reflected in the next registered level/full.
  - A read freeing the last slot while wr_inc is high: the write is refused if wr_full is high in that cycle, and accepted on the following cycle.
- r2w_ptr is trusted to be a valid Gray code (one-bit changes); no checking is done.

Test Plan:
- Reset, then 16 consecutive wr_inc with r2w_ptr=0 (ASIZE=4) -> wr_addr steps 0..15; wr_full rises on the edge accepting write 16; wr_level=16; wr_ptr=5'b11000.
- Continuing from full, assert wr_inc for 2 cycles -> wr_en=0, wbin held at 16, wr_overflow=1. Then pulse ovf_clr -> wr_overflow=0.
- From full, drive r2w_ptr to Gray(1)=5'b00001 -> next edge wr_full=0, wr_level=15, wr_almost_full=1 (AF_MARGIN=2). Next wr_inc accepted at wr_addr=0.
- Steady 1-in/1-out traffic for 40 writes with r2w_ptr tracking wbin-3 -> wbin wraps past 31 to 0; wr_ptr changes one bit per cycle; wr_level constant at 3; wr_full never asserts.
- Almost-full threshold: fill to 13 -> wr_almost_full=0; 14th write -> wr_almost_full=1 on that edge.
- Assert wr_rst_n low mid-burst at level 9 -> all outputs 0 immediately, before the next clock edge. Writes resume at wr_addr=0 after release.
